cam_pattern_gen: RTL and testbench

- Synthetic camera source for the 2PPC raw pixel path.
- Emits frame-framed vsync/valid/pixel beats in exactly the format the camera line buffer and debayer chain consume.
- Selectable test patterns let the downstream pipeline be brought up and regressed without a sensor.
- Sits in the cam block, muxed in front of the line buffer.

---
 rtl/cam_pattern_gen.sv | 248 ++++++++++++++++++++++++
 tb/tb_cam_pattern_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: synthetic 2PPC raw camera source (vsync/valid/pixel beats).
// Ports: i_pclk, i_arstn, i_en, i_mode -> o_vsync, o_valid, o_p, o_frame_cnt,
//   o_checksum, o_checksum_valid. Optional: CAM_PATTERN_GEN_CHECKSUM_EN.
module cam_pattern_gen #(
  parameter int P_DEPTH      = 10,
  parameter int PW           = P_DEPTH * 2,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int H_BLANK      = 32,
  parameter int VS_LEAD      = 8,
  parameter int VS_TRAIL     = 8,
  parameter int V_BLANK      = 64
) (
  input  logic          i_pclk,
  input  logic          i_arstn,
  input  logic          i_en,
  input  logic [1:0]    i_mode,
  output logic          o_vsync,
  output logic          o_valid,
  output logic [PW-1:0] o_p,
  output logic [7:0]    o_frame_cnt,
  output logic [15:0]   o_checksum,
  output logic          o_checksum_valid
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int BEATS = FRAME_WIDTH / 2;
  localparam int XW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int BMAX  =
    max2(max2(VS_LEAD, H_BLANK), max2(VS_TRAIL, V_BLANK));
  localparam int CW    = (BMAX > 1) ? $clog2(BMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VS_LEAD,
    S_ACTIVE,
    S_HBLANK,
    S_VS_TRAIL,
    S_VBLANK
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            vsync_q, vsync_d;
  logic            valid_q, valid_d;
  logic [PW-1:0]   p_q, p_d;
  logic            start;
  logic            frame_done;

  logic [P_DEPTH-1:0] col_lo, col_hi, pix_lo, pix_hi;
  logic [XW+3:0]      x_pad;
  logic [YW+3:0]      y_pad;
  logic               chk_on;
  logic               unused_pad;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    start       = 1'b0;
    frame_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_en) begin
          state_d = S_VS_LEAD;
          cnt_d   = '0;
          mode_d  = i_mode;
          start   = 1'b1;
        end
      end
      S_VS_LEAD: begin
        if (cnt_q == CW'(VS_LEAD - 1)) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACTIVE: begin
        if (x_q == XW'(BEATS - 1)) begin
          x_d   = '0;
          cnt_d = '0;
          if (y_q == YW'(FRAME_HEIGHT - 1)) begin
            state_d = S_VS_TRAIL;
          end else begin
            state_d = S_HBLANK;
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      S_HBLANK: begin
        if (cnt_q == CW'(H_BLANK - 1)) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          y_d     = y_q + YW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VS_TRAIL: begin
        if (cnt_q == CW'(VS_TRAIL - 1)) begin
          state_d     = S_VBLANK;
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          frame_done  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VBLANK: begin
        if (cnt_q == CW'(V_BLANK - 1)) begin
          cnt_d = '0;
          if (i_en) begin
            state_d = S_VS_LEAD;
            mode_d  = i_mode;
            start   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel of the beat about to be registered; column c = 2x / 2x+1,
  // so c[3] is x[2].
  assign x_pad      = (XW + 4)'(x_d);
  assign y_pad      = (YW + 4)'(y_d);
  assign chk_on     = x_pad[2] ^ y_pad[3];
  assign unused_pad = ^{x_pad, y_pad};

  always_comb begin
    col_lo = P_DEPTH'({x_d, 1'b0});
    col_hi = col_lo | P_DEPTH'(1);
    pix_lo = '0;
    pix_hi = '0;
    unique case (mode_q)
      2'd0: begin
        pix_lo = col_lo;
        pix_hi = col_hi;
      end
      2'd1: begin
        pix_lo = P_DEPTH'(y_d);
        pix_hi = P_DEPTH'(y_d);
      end
      2'd2: begin
        pix_lo = chk_on ? '1 : '0;
        pix_hi = chk_on ? '1 : '0;
      end
      2'd3: begin
        pix_lo = P_DEPTH'(frame_cnt_q);
        pix_hi = P_DEPTH'(frame_cnt_q);
      end
    endcase
  end

  always_comb begin
    valid_d = (state_d == S_ACTIVE);
    vsync_d = (state_d == S_VS_LEAD) || (state_d == S_ACTIVE) ||
              (state_d == S_HBLANK)  || (state_d == S_VS_TRAIL);
    p_d     = valid_d ? PW'({pix_hi, pix_lo}) : '0;
  end

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b0;
      valid_q     <= 1'b0;
      p_q         <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      valid_q     <= valid_d;
      p_q         <= p_d;
    end
  end

  assign o_vsync     = vsync_q;
  assign o_valid     = valid_q;
  assign o_p         = p_q;
  assign o_frame_cnt = frame_cnt_q;

`ifdef CAM_PATTERN_GEN_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [15:0] cks_q, cks_d;
  logic        ckv_q, ckv_d;

  // The last beat is already in sum_q when VS_TRAIL ends.
  always_comb begin
    sum_d = sum_q;
    if (start) begin
      sum_d = '0;
    end else if (valid_d) begin
      sum_d = sum_q + 16'(pix_lo) + 16'(pix_hi);
    end
    cks_d = frame_done ? sum_q : cks_q;
    ckv_d = frame_done;
  end

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      sum_q <= '0;
      cks_q <= '0;
      ckv_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cks_q <= cks_d;
      ckv_q <= ckv_d;
    end
  end

  assign o_checksum       = cks_q;
  assign o_checksum_valid = ckv_q;
`else
  logic unused_cks;
  assign unused_cks       = frame_done ^ start;
  assign o_checksum       = '0;
  assign o_checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb_cam_pattern_gen: directed vector bench for cam_pattern_gen.
// Small frame: 8x4, H_BLANK 2, VS_LEAD 3, VS_TRAIL 3, V_BLANK 5.
module tb_cam_pattern_gen;
  localparam int PD = 10;
  localparam int PW = 20;
`ifdef CAM_PATTERN_GEN_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          en2 = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    mode2 = 2'd2;
  logic          vs, va, ckv;
  logic [PW-1:0] p;
  logic [7:0]    fc;
  logic [15:0]   cks;
  logic          vs2, va2, ckv2;
  logic [PW-1:0] p2;
  logic [7:0]    fc2;
  logic [15:0]   cks2;

  always #5 clk = ~clk;

  cam_pattern_gen #(
    .P_DEPTH(PD), .PW(PW), .FRAME_WIDTH(8), .FRAME_HEIGHT(4),
    .H_BLANK(2), .VS_LEAD(3), .VS_TRAIL(3), .V_BLANK(5)
  ) dut (
    .i_pclk(clk), .i_arstn(rst_n), .i_en(en), .i_mode(mode),
    .o_vsync(vs), .o_valid(va), .o_p(p), .o_frame_cnt(fc),
    .o_checksum(cks), .o_checksum_valid(ckv)
  );

  cam_pattern_gen #(
    .P_DEPTH(PD), .PW(PW), .FRAME_WIDTH(32), .FRAME_HEIGHT(4),
    .H_BLANK(2), .VS_LEAD(3), .VS_TRAIL(3), .V_BLANK(5)
  ) dut2 (
    .i_pclk(clk), .i_arstn(rst_n), .i_en(en2), .i_mode(mode2),
    .o_vsync(vs2), .o_valid(va2), .o_p(p2), .o_frame_cnt(fc2),
    .o_checksum(cks2), .o_checksum_valid(ckv2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  logic [PW-1:0] beats[$];
  logic [PW-1:0] fb[6][16];

  logic [PW-1:0] b2[16];
  int            n2 = 0;
  always @(negedge clk) begin
    if (va2 && n2 < 16) begin
      b2[n2] <= p2;
      n2     <= n2 + 1;
    end
  end

  task automatic capture(
    input  int          chg_at,
    input  logic [1:0]  chg_mode,
    input  int          drop_at,
    output int          pre_low,
    output int          lead,
    output int          vs_len,
    output int          gaps,
    output int          ckv_cnt,
    output logic [15:0] cks_f,
    output logic [7:0]  fc_f,
    output logic        ckv_f
  );
    int gap_run;
    int n;
    beats.delete();
    pre_low = 0; lead = 0; vs_len = 0; gaps = 0; ckv_cnt = 0;
    gap_run = 0; cks_f = '0; fc_f = '0; ckv_f = 1'b0;
    n = 0;
    @(negedge clk);
    while (!vs && n < 200) begin
      if (ckv) ckv_cnt++;
      pre_low++;
      n++;
      @(negedge clk);
    end
    if (!vs) begin
      chk("vsync_rise_timeout", vs, 1);
      return;
    end
    n = 0;
    while (vs && n < 1000) begin
      vs_len++;
      n++;
      if (ckv) ckv_cnt++;
      if (va) begin
        if (beats.size() > 0) gaps += gap_run;
        gap_run = 0;
        beats.push_back(p);
        if (beats.size() == chg_at) mode = chg_mode;
        if (beats.size() == drop_at) en = 1'b0;
      end else if (beats.size() == 0) begin
        lead++;
      end else begin
        gap_run++;
      end
      @(negedge clk);
    end
    if (vs) begin
      chk("vsync_fall_timeout", vs, 0);
      return;
    end
    cks_f = cks;
    fc_f  = fc;
    ckv_f = ckv;
  endtask

  task automatic store(input int f);
    for (int i = 0; i < 16; i++) begin
      fb[f][i] = (i < beats.size()) ? beats[i] : 'x;
    end
  endtask

  typedef struct {
    string         name;
    int            f;
    int            b;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [PW-1:0] line0[4];
    logic [PW-1:0] rowv[4];
    int            pl, ld, vl, gp, cc;
    logic [15:0]   cf;
    logic [7:0]    ff;
    logic          kf;
    int            bad, n;
    logic [PW-1:0] m3;
    logic [7:0]    kk;

    line0 = '{20'h00400, 20'h00C02, 20'h01404, 20'h01C06};
    rowv  = '{20'h00000, 20'h00401, 20'h00802, 20'h00C03};
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        vt.push_back('{"mode0_beat", 0, y * 4 + x, line0[x]});
        vt.push_back('{"mode1_beat", 1, y * 4 + x, rowv[y]});
      end
    end
    vt.push_back('{"mode2_w8_beat", 2, 0, 20'h00000});
    vt.push_back('{"mode2_w8_beat", 2, 6, 20'h00000});
    vt.push_back('{"mode2_w8_beat", 2, 15, 20'h00000});
    vt.push_back('{"drop_en_beat", 3, 15, 20'h01C06});
    vt.push_back('{"restart_beat", 4, 0, 20'h00400});
    vt.push_back('{"restart_beat", 4, 3, 20'h01C06});
    vt.push_back('{"post_reset_beat", 5, 0, 20'h00400});
    vt.push_back('{"post_reset_beat", 5, 1, 20'h00C02});
    vt.push_back('{"post_reset_beat", 5, 15, 20'h01C06});

    repeat (3) @(negedge clk);
    chk("rst_vsync", vs, 0);
    chk("rst_valid", va, 0);
    chk("rst_p", p, 0);
    chk("rst_frame_cnt", fc, 0);
    chk("rst_checksum", cks, 0);
    chk("rst_checksum_valid", ckv, 0);

    rst_n = 1'b1;
    en2   = 1'b1;
    mode  = 2'd0;
    en    = 1'b1;

    // Frame 0: mode 0; mode 1 is queued for the next frame.
    capture(-1, 2'd0, -1, pl, ld, vl, gp, cc, cf, ff, kf);
    store(0);
    chk("f0_pre_low", pl, 0);
    chk("f0_lead", ld, 3);
    chk("f0_vsync_len", vl, 28);
    chk("f0_beats", beats.size(), 16);
    chk("f0_gap_cycles", gp, 6);
    chk("f0_ckv_in_frame", cc, 0);
    chk("f0_ckv_at_fall", kf, CK);
    chk("f0_checksum", cf, CK ? 16'h0070 : 16'h0000);
    chk("f0_frame_cnt", ff, 1);
    mode = 2'd1;

    // Frame 1: mode 1, switched to 2 mid-frame.
    capture(5, 2'd2, -1, pl, ld, vl, gp, cc, cf, ff, kf);
    store(1);
    chk("f1_vblank_gap", pl + 1, 5);
    chk("f1_vsync_len", vl, 28);
    chk("f1_ckv_pulses", cc, 0);
    chk("f1_checksum", cf, CK ? 16'h0030 : 16'h0000);
    chk("f1_frame_cnt", ff, 2);

    // Frame 2: mode 2 picked up at frame start.
    capture(-1, 2'd0, -1, pl, ld, vl, gp, cc, cf, ff, kf);
    store(2);
    chk("f2_checksum", cf, 16'h0000);
    chk("f2_frame_cnt", ff, 3);
    mode = 2'd0;

    // Frame 3: enable dropped after 5 beats.
    capture(-1, 2'd0, 5, pl, ld, vl, gp, cc, cf, ff, kf);
    store(3);
    chk("f3_vsync_len", vl, 28);
    chk("f3_beats", beats.size(), 16);
    chk("f3_frame_cnt", ff, 4);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (vs || va) bad++;
    end
    chk("idle_no_vsync", bad, 0);

    // Frame 4: restart from IDLE.
    en = 1'b1;
    capture(-1, 2'd0, -1, pl, ld, vl, gp, cc, cf, ff, kf);
    store(4);
    chk("f4_vsync_next_cycle", pl, 0);
    chk("f4_lead", ld, 3);
    chk("f4_frame_cnt", ff, 5);

    // Asynchronous reset during ACTIVE.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!va && n < 100);
    chk("reach_active", va, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vsync", vs, 0);
    chk("arst_valid", va, 0);
    chk("arst_p", p, 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (vs || va) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    chk("post_reset_frame_cnt", fc, 0);

    en   = 1'b1;
    mode = 2'd0;
    capture(-1, 2'd0, -1, pl, ld, vl, gp, cc, cf, ff, kf);
    store(5);
    chk("f5_frame_cnt", ff, 1);
    mode = 2'd3;

    // Mode 3 for 256 frames, across the counter wrap.
    for (int k = 1; k <= 256; k++) begin
      capture(-1, 2'd3, -1, pl, ld, vl, gp, cc, cf, ff, kf);
      kk  = 8'(k);
      m3  = {2'b00, kk, 2'b00, kk};
      bad = (beats.size() == 16) ? 0 : 1;
      foreach (beats[i]) if (beats[i] !== m3) bad++;
      chk($sformatf("m3_f%0d_beats", k), bad, 0);
      chk($sformatf("m3_f%0d_cnt", k), ff, 8'(kk + 8'd1));
      chk($sformatf("m3_f%0d_cks", k), cf,
          CK ? 32'(16'(32 * int'(kk))) : 32'd0);
    end
    en = 1'b0;

    foreach (vt[i]) begin
      chk($sformatf("%s_f%0d_b%0d", vt[i].name, vt[i].f, vt[i].b),
          fb[vt[i].f][vt[i].b], vt[i].exp);
    end

    chk("w32_beats", n2, 16);
    chk("w32_x0", b2[0], 20'h00000);
    chk("w32_x3", b2[3], 20'h00000);
    chk("w32_x4", b2[4], 20'hFFFFF);
    chk("w32_x7", b2[7], 20'hFFFFF);
    chk("w32_x8", b2[8], 20'h00000);
    chk("w32_x12", b2[12], 20'hFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
